sumador_segmentado: RTL and testbench
=====================================

Name: sumador_segmentado

Overview:
Parametrised, pipelined integer adder/subtractor. It is the next generation of the datapath sumador. The operand width is split into STAGES equal slices, and the carry ripples one slice per clock. The block carries a valid/ready handshake and produces carry, signed-overflow and zero flags. It is used wherever the multicycle and pipelined datapath variants need a high-fmax, wide add/sub with backpressure.

Parameters:
WIDTH, 32, operand and result width in bits. WIDTH % STAGES must be 0 and WIDTH >= 2.
STAGES, 4, number of pipeline stages, i.e. slices of WIDTH/STAGES bits. Range 1..WIDTH.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  operand beat present.
in_ready  out  1  block accepts a beat this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
op  in  1  0 = ADD, 1 = SUB (A - B).
cin  in  1  carry-in. Used only when op = ADD; ignored for SUB.
out_valid  out  1  result beat present.
out_ready  in  1  consumer accepts the result.
s  out  WIDTH  sum or difference, modulo 2^WIDTH.
cout  out  1  carry out of the MSB. For SUB this is NOT borrow: 1 means A >= B unsigned.
ovf  out  1  signed two's-complement overflow.
zero  out  1  s == 0.

Behaviour:
- Reset (async assert, sync release by the user):
  - all stage valid bits clear to 0; out_valid = 0.
  - s = 0, cout = 0, ovf = 0, zero = 0.
  - in-flight beats are discarded; none emerge after release.
- Operand conditioning at stage 0 entry:
  - for SUB, the effective B is ~b and the effective carry-in is 1.
  - for ADD, the effective B is b and the effective carry-in is cin.
- Slice k (k = 0..STAGES-1) adds bits [k*W+W-1 : k*W], with W = WIDTH/STAGES, using the carry registered from slice k-1.
  - Unprocessed upper operand bits and the already-computed lower result bits travel alongside in pipeline registers.
- Final stage computes:
  - cout = carry out of the MSB slice.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - zero = NOR of the full result.
  - All outputs are registered.
- Latency: exactly STAGES cycles from an accepted beat to out_valid for that beat, given no stall. Throughput is 1 beat per cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational path from out_ready; documented, accepted).
  - A beat is accepted when in_valid && in_ready.
  - When advance = 1, every stage shifts forward one position. A stage with no beat loads valid = 0 (bubble).
  - When advance = 0, all stage registers and outputs hold.
  - s, cout, ovf and zero are stable while out_valid && !out_ready.
- Ordering: results emerge in acceptance order, never dropped and never duplicated.
- Simultaneous in_valid with a stall: the beat is not accepted; the source must hold it (AXI-style rules: valid must not drop before acceptance).
- Bubbles: a bubble may be overwritten only via normal advance. The pipeline does not collapse bubbles (simple global enable).
- Wrap-around: the result is modulo 2^WIDTH; cout and ovf report the excess.
- STAGES = 1 degenerates to a single registered add/sub with latency 1.
- Values on a, b, op and cin are don't-care when in_valid = 0.

Decomposition:
- Package sumador_pkg:
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Elaboration-time check function asserting WIDTH % STAGES == 0.
- Sub-module sumador_tramo: combinational slice adder with parameter W; inputs a, b, ci; outputs s, co, plus the carry into its MSB for overflow.
- Top level generates STAGES instances of sumador_tramo plus the pipeline registers and the handshake logic.

Test Plan:
1. WIDTH=32, STAGES=4. ADD a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 → after 4 cycles out_valid=1, s=0x00000000, cout=1, ovf=0, zero=1.
2. SUB a=5, b=7 → s=0xFFFFFFFE, cout=0, ovf=0, zero=0. Then SUB a=7, b=5 → s=2, cout=1.
3. ADD a=0x7FFFFFFF, b=1, cin=0 → s=0x80000000, ovf=1, cout=0. Also ADD a=0x10, b=0x20, cin=1 → s=0x31.
4. Stream 8 back-to-back ADDs (a=i, b=100); hold out_ready=0 for 3 cycles mid-stream → in_ready=0 during the stall, outputs held stable, all 8 results 100..107 delivered in order with no gaps or duplicates.
5. Accept 3 beats, assert reset asynchronously mid-cycle → out_valid=0 and s=0 immediately. After release with in_valid=0 for 6 cycles, out_valid stays 0.
6. WIDTH=8, STAGES=1 instance: SUB a=0x80, b=0x01 → after 1 cycle s=0x7F, ovf=1, cout=1, zero=0.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared opcodes and parameter sanity check for the pipelined adder/subtractor.
package sumador_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // True when the operand width splits into equal, non-empty slices.
   function automatic logic slices_ok(input int width, input int stages);
      if (stages < 1 || stages > width || width < 2) return 1'b0;
      return (width % stages) == 0;
   endfunction

endpackage

// File: rtl/sumador_tramo.sv
// Combinational W-bit slice adder; also reports the carry into its MSB for overflow detection.
module sumador_tramo #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb
);

   logic [W:0] sum;

   assign sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   assign s     = sum[W-1:0];
   assign co    = sum[W];
   // Carry into the MSB recovered from the MSB sum bit.
   assign c_msb = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/sumador_segmentado.sv
// Pipelined add/sub: the carry ripples one WIDTH/STAGES slice per clock, with valid/ready backpressure.
module sumador_segmentado
   import sumador_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int W    = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;
   localparam logic [WIDTH-1:0] LOW_ONES = {WIDTH{1'b1}} >> (WIDTH - W);

   generate
      if (!slices_ok(WIDTH, STAGES)) begin : g_param_check
         $error("sumador_segmentado: WIDTH must be >= 2 and a multiple of STAGES");
      end
   endgenerate

   // Registered state after each stage: operands, partial result, carry, valid.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             ovf_q;
   logic             zero_q;

   // Values presented to each stage's slice adder.
   logic [WIDTH-1:0] op_a   [STAGES];
   logic [WIDTH-1:0] op_b   [STAGES];
   logic [WIDTH-1:0] s_prev [STAGES];
   logic [WIDTH-1:0] s_next [STAGES];
   logic             ci     [STAGES];
   logic             v_in   [STAGES];
   logic [W-1:0]     slice_s  [STAGES];
   logic             slice_co [STAGES];
   logic             slice_cm [STAGES];
   logic             advance;

   // Handshake: a beat moves on an edge where valid && ready. advance = !out_valid || out_ready
   // is the single global enable; in_ready = advance (combinational from out_ready). When
   // advance is low every register, including the outputs, holds its value.
   assign advance   = !v_q[LAST] || out_ready;
   assign in_ready  = advance;
   assign out_valid = v_q[LAST];
   assign s         = s_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_head
            // SUB is A + ~B + 1; cin only matters for ADD.
            assign op_a[k]   = a;
            assign op_b[k]   = (op == OP_SUB) ? ~b : b;
            assign ci[k]     = (op == OP_SUB) ? 1'b1 : cin;
            assign v_in[k]   = in_valid;
            assign s_prev[k] = '0;
         end else begin : g_body
            assign op_a[k]   = a_q[k-1];
            assign op_b[k]   = b_q[k-1];
            assign ci[k]     = c_q[k-1];
            assign v_in[k]   = v_q[k-1];
            assign s_prev[k] = s_q[k-1];
         end

         sumador_tramo #(.W(W)) u_tramo (
            .a     (op_a[k][k*W +: W]),
            .b     (op_b[k][k*W +: W]),
            .ci    (ci[k]),
            .s     (slice_s[k]),
            .co    (slice_co[k]),
            .c_msb (slice_cm[k])
         );

         assign s_next[k] = (s_prev[k] & ~(LOW_ONES << (k*W)))
                          | (WIDTH'(slice_s[k]) << (k*W));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            v_q[i] <= 1'b0;
            a_q[i] <= '0;
            b_q[i] <= '0;
            s_q[i] <= '0;
            c_q[i] <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (advance) begin
         for (int i = 0; i < STAGES; i++) begin
            v_q[i] <= v_in[i];
            a_q[i] <= op_a[i];
            b_q[i] <= op_b[i];
            s_q[i] <= s_next[i];
            c_q[i] <= slice_co[i];
         end
         ovf_q  <= slice_cm[LAST] ^ slice_co[LAST];
         zero_q <= ~|s_next[LAST];
      end
   end

endmodule

// File: tb/tb_sumador_segmentado.sv
// Directed bench for sumador_segmentado: 32-bit/4-stage and 8-bit/1-stage instances.
module tb_sumador_segmentado;
   import sumador_pkg::*;

   localparam int WIDTH = 32;
   localparam int EW    = WIDTH + 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid, in_ready, op, cin, out_valid, out_ready, cout, ovf, zero;
   logic [WIDTH-1:0] a, b, s;

   logic             in_valid8, in_ready8, op8, cin8, out_valid8, out_ready8, cout8, ovf8, zero8;
   logic [7:0]       a8, b8, s8;

   int               total = 0;
   int               bad   = 0;
   int               n_out = 0;
   logic             mon_en;
   logic [EW-1:0]    exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   sumador_segmentado #(.WIDTH(WIDTH), .STAGES(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf), .zero(zero)
   );

   sumador_segmentado #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .op(op8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8)
   );

   function automatic logic [EW-1:0] pack(input logic [WIDTH-1:0] s_v, input logic c, input logic o,
                                          input logic z);
      return {z, o, c, s_v};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic opv,
                       input logic cv, input logic [EW-1:0] expv);
      int n = 0;
      @(negedge clk);
      a = av; b = bv; op = opv; cin = cv; in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept", 64'(in_ready), 64'd1);
      if (in_ready) exp_q.push_back(expv);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic stall_mid_stream();
      int n = 0;
      logic [EW-1:0] held;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #2 out_ready = 1'b0;
      held = pack(s, cout, ovf, zero);
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_hold", 64'(pack(s, cout, ovf, zero)), 64'(held));
      end
      @(posedge clk);
      #2 out_ready = 1'b1;
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!reset && mon_en && out_valid && out_ready) begin
         check("result_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            check($sformatf("result%0d", n_out), 64'(pack(s, cout, ovf, zero)), 64'(exp_q.pop_front()));
            n_out++;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      reset = 1'b1; mon_en = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; cin = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = OP_ADD; cin8 = 1'b0; out_ready8 = 1'b1;
      #1;
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_outputs", 64'(pack(s, cout, ovf, zero)), 64'd0);
      check("reset8", 64'({out_valid8, zero8, ovf8, cout8, s8}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Carry across all slices, result wraps to zero; measure latency.
      send(32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, pack(32'h0, 1'b1, 1'b0, 1'b1));
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'd4);
      drain();

      // Subtraction (cin ignored), signed overflow, add with carry-in.
      send(32'd5, 32'd7, OP_SUB, 1'b1, pack(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
      send(32'd7, 32'd5, OP_SUB, 1'b0, pack(32'h2, 1'b1, 1'b0, 1'b0));
      send(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0, pack(32'h8000_0000, 1'b0, 1'b1, 1'b0));
      send(32'h10, 32'h20, OP_ADD, 1'b1, pack(32'h31, 1'b0, 1'b0, 1'b0));
      send(32'h8000_0000, 32'h1, OP_SUB, 1'b0, pack(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
      send(32'h1234_5678, 32'h1234_5678, OP_SUB, 1'b0, pack(32'h0, 1'b1, 1'b0, 1'b1));
      drain();

      // Back-to-back stream with a three-cycle consumer stall in the middle.
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(32'(i), 32'd100, OP_ADD, 1'b0, pack(32'(100 + i), 1'b0, 1'b0, 1'b0));
         end
         stall_mid_stream();
      join
      drain();
      check("stream_count", 64'(n_out), 64'd15);

      // Asynchronous reset with beats in flight: nothing emerges afterwards.
      mon_en = 1'b0;
      send(32'd1, 32'd2, OP_ADD, 1'b0, pack(32'd3, 1'b0, 1'b0, 1'b0));
      send(32'd3, 32'd4, OP_ADD, 1'b0, pack(32'd7, 1'b0, 1'b0, 1'b0));
      send(32'd5, 32'd6, OP_ADD, 1'b0, pack(32'd11, 1'b0, 1'b0, 1'b0));
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("pre_reset_s", 64'(s), 64'd3);
      #2 reset = 1'b1;
      #1;
      check("async_reset_valid", 64'(out_valid), 64'd0);
      check("async_reset_outputs", 64'(pack(s, cout, ovf, zero)), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("post_reset_idle", 64'(out_valid), 64'd0);
      end
      exp_q.delete();
      mon_en = 1'b1;

      // Single-stage 8-bit instance: latency 1, signed overflow on SUB.
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h01; op8 = OP_SUB; cin8 = 1'b0; in_valid8 = 1'b1;
      check("s1_in_ready", 64'(in_ready8), 64'd1);
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      @(negedge clk);
      check("s1_valid", 64'(out_valid8), 64'd1);
      check("s1_result", 64'({zero8, ovf8, cout8, s8}), 64'({1'b0, 1'b1, 1'b1, 8'h7F}));
      @(negedge clk);
      check("s1_bubble", 64'(out_valid8), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
